// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: PC generation, imem request/response tracking, fetch FIFO, redirect flush.
// Optional feature: define IFU_PERF_COUNTERS_EN to add the perf_fetched / perf_dropped counter outputs.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(BUF_DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [31:0]   NOP_INSN  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] pcq_rd_q, pcq_rd_d;
    logic [PW-1:0] pcq_wr_q, pcq_wr_d;
    logic [31:0]   last_pc_q;

    fetch_entry_t  fifo_mem [BUF_DEPTH];
    logic [31:0]   pcq_mem  [BUF_DEPTH];

    logic [CW:0]   occupancy;
    logic          req_fire;
    logic          fifo_empty;
    logic          pop;
    logic          resp_drop;
    logic          push;
    fetch_entry_t  head;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Space is reserved at issue time, so every response that is kept always has a FIFO slot.
    assign occupancy      = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
    assign imem_req_valid = !reset && !redirect_valid
                            && (occupancy < DEPTH_C) && (outstanding_q < MAX_OUT_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_empty  = (fifo_cnt_q == '0);
    assign head        = fifo_mem[fifo_rd_q];
    assign instr_valid = !reset && !redirect_valid && !fifo_empty;
    assign instruction = fifo_empty ? NOP_INSN : head.word;
    assign instr_pc    = fifo_empty ? last_pc_q : head.pc;
    assign pop         = instr_valid && instr_ready;

    assign resp_drop = imem_resp_valid && (redirect_valid || (drop_cnt_q != '0));
    assign push      = imem_resp_valid && !resp_drop;

    // NOTE: always_comb assigns every target a default first so no latch is inferred.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        pcq_rd_d      = pcq_rd_q;
        pcq_wr_d      = pcq_wr_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pcq_wr_d   = pcq_wr_q + PW'(1);
        end
        if (imem_resp_valid) begin
            pcq_rd_d = pcq_rd_q + PW'(1);
        end
        if (imem_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        if (push) begin
            fifo_wr_d = fifo_wr_q + PW'(1);
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + PW'(1);
        end

        // Redirect wins: everything still in flight becomes stale and is dropped on return.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            drop_cnt_d = outstanding_q - CW'(imem_resp_valid);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
            last_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            pcq_wr_q      <= pcq_wr_d;
            last_pc_q     <= instr_pc;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_q] <= '{word: imem_resp_data, pc: pcq_mem[pcq_rd_q]};
        end
        if (req_fire) begin
            pcq_mem[pcq_wr_q] <= fetch_pc_q;
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_dropped_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_dropped_q <= perf_dropped_q + 32'(resp_drop)
                              + (redirect_valid ? 32'(fifo_cnt_q) : 32'd0);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (imem_req_valid && !imem_req_ready)
        |=> (redirect_valid || (imem_req_valid && $stable(imem_req_addr))));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push && !pop && !redirect_valid) |-> ({1'b0, fifo_cnt_q} < DEPTH_C));

endmodule
